// File: rtl/tt_um_tv_b_gone_core.sv
// TV-B-Gone core: sends four NEC IR frames on a start edge.
// uo_out = {3'b0, code index[1:0], busy, envelope, ir_out}.
// Optional feature: define TVBG_REPEAT_EN so that ui_in[2] held high loops
// the sequence back to frame 0 after the last gap. Without the macro,
// ui_in[2] is ignored.
// Reset is synchronous and active-high on the port named rst_n.
// Handshake: none. start (ui_in[0]) is a level whose synchronized rising
// edge launches a sequence from IDLE only. abort (ui_in[1]) is a level
// that returns to IDLE while high and wins over start.
module tt_um_tv_b_gone_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [1:0]  fill_q;
  logic        start_prev_q, start_prev_d;
  logic [1:0]  idx_q, idx_d;
  logic [4:0]  bit_q, bit_d;
  logic        fast_q, fast_d;
  logic [12:0] tick_q, tick_d;
  logic [6:0]  unit_q, unit_d;
  logic        carrier_q, carrier_d;
  logic [7:0]  car_cnt_q, car_cnt_d;

  logic        start_s, abort_s, rep_s, start_edge;
  logic        is_mark, busy, cur_bit, tick_end, state_done;
  logic [31:0] word;
  logic [12:0] tick_last;
  logic [7:0]  half_last;
  logic [6:0]  dur_last;
  logic        unused_ok;

  // NEC payload in transmit order: bit 0 of the result goes out first.
  function automatic logic [31:0] frame_word(input logic [1:0] idx);
    logic [7:0] a;
    logic [7:0] c;
    case (idx)
      2'd0:    begin a = 8'h04; c = 8'h08; end
      2'd1:    begin a = 8'h40; c = 8'h12; end
      2'd2:    begin a = 8'h00; c = 8'h45; end
      default: begin a = 8'h20; c = 8'h0C; end
    endcase
    return {~c, c, ~a, a};
  endfunction

  assign start_s = sync2_q[0];
  assign abort_s = sync2_q[1];
  assign rep_s   = sync2_q[2];
  assign start_edge = start_s & ~start_prev_q;

  // Input synchronizers and start edge history. start_prev_q resets to 1 and
  // stays 1 until the synchronizer holds real samples, so a start input that
  // is already high when reset releases never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q      <= 3'b000;
      sync2_q      <= 3'b000;
      fill_q       <= 2'b00;
      start_prev_q <= 1'b1;
    end else begin
      sync1_q      <= ui_in[2:0];
      sync2_q      <= sync1_q;
      fill_q       <= {fill_q[0], 1'b1};
      start_prev_q <= start_prev_d;
    end
  end

  assign start_prev_d = fill_q[1] ? start_s : 1'b1;

  assign is_mark = (state_q == S_LEAD_MARK) || (state_q == S_BIT_MARK) ||
                   (state_q == S_STOP_MARK);
  assign busy    = (state_q != S_IDLE);

  // Next state, tick/unit timers, bit/frame counters and carrier.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    fast_d    = fast_q;
    tick_d    = tick_q;
    unit_d    = unit_q;
    carrier_d = carrier_q;
    car_cnt_d = car_cnt_q;

    word      = frame_word(idx_q);
    cur_bit   = word[bit_q];
    tick_last = fast_q ? 13'd7 : 13'd5624;
    half_last = fast_q ? 8'd1 : 8'd131;

    case (state_q)
      S_LEAD_MARK:  dur_last = 7'd15;
      S_LEAD_SPACE: dur_last = 7'd7;
      S_BIT_SPACE:  dur_last = cur_bit ? 7'd2 : 7'd0;
      S_GAP:        dur_last = 7'd63;
      default:      dur_last = 7'd0;
    endcase

    tick_end   = (tick_q == tick_last);
    state_done = tick_end && (unit_q == dur_last);

    if (abort_s) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      bit_d   = 5'd0;
      tick_d  = 13'd0;
      unit_d  = 7'd0;
    end else if (state_q == S_IDLE) begin
      tick_d = 13'd0;
      unit_d = 7'd0;
      idx_d  = 2'd0;
      bit_d  = 5'd0;
      if (start_edge) begin
        state_d = S_LEAD_MARK;
        fast_d  = ui_in[7];
      end
    end else if (state_done) begin
      tick_d = 13'd0;
      unit_d = 7'd0;
      case (state_q)
        S_LEAD_MARK:  state_d = S_LEAD_SPACE;
        S_LEAD_SPACE: state_d = S_BIT_MARK;
        S_BIT_MARK:   state_d = S_BIT_SPACE;
        S_BIT_SPACE: begin
          if (bit_q == 5'd31) begin
            state_d = S_STOP_MARK;
            bit_d   = 5'd0;
          end else begin
            state_d = S_BIT_MARK;
            bit_d   = bit_q + 5'd1;
          end
        end
        S_STOP_MARK:  state_d = S_GAP;
        S_GAP: begin
          if (idx_q != 2'd3) begin
            state_d = S_LEAD_MARK;
            idx_d   = idx_q + 2'd1;
          end else begin
`ifdef TVBG_REPEAT_EN
            state_d = rep_s ? S_LEAD_MARK : S_IDLE;
`else
            state_d = S_IDLE;
`endif
            idx_d   = 2'd0;
          end
        end
        default:      state_d = S_IDLE;
      endcase
    end else if (tick_end) begin
      tick_d = 13'd0;
      unit_d = unit_q + 7'd1;
    end else begin
      tick_d = tick_q + 13'd1;
    end

    // Carrier is preloaded high outside marks so each mark starts in phase.
    if (!is_mark) begin
      carrier_d = 1'b1;
      car_cnt_d = 8'd0;
    end else if (car_cnt_q == half_last) begin
      carrier_d = ~carrier_q;
      car_cnt_d = 8'd0;
    end else begin
      car_cnt_d = car_cnt_q + 8'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      bit_q     <= 5'd0;
      fast_q    <= 1'b0;
      tick_q    <= 13'd0;
      unit_q    <= 7'd0;
      carrier_q <= 1'b0;
      car_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      fast_q    <= fast_d;
      tick_q    <= tick_d;
      unit_q    <= unit_d;
      carrier_q <= carrier_d;
      car_cnt_q <= car_cnt_d;
    end
  end

  assign uo_out  = {3'b000, idx_q, busy, is_mark, is_mark & carrier_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign unused_ok = &{1'b0, ena, uio_in, ui_in[6:3], rep_s};

endmodule

// File: tb/tb_tt_um_tv_b_gone_core.sv
// Bench for tt_um_tv_b_gone_core, run in fast mode (ui_in[7]=1).
// Expected output streams come from a frame-level model of the NEC sequence.
module tb_tt_um_tv_b_gone_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit         env_hist[$];

  logic [7:0] addr_t[4] = '{8'h04, 8'h40, 8'h00, 8'h20};
  logic [7:0] cmd_t[4]  = '{8'h08, 8'h12, 8'h45, 8'h0C};

  tt_um_tv_b_gone_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    ui_in = 8'h80;
    step();
    step();
    rst_n = 1'b0;
    repeat (5) step();
  endtask

  // model: one segment of `ticks` 8-clock ticks, mark or space
  task automatic push_seg(input bit mark, input int ticks, input int idx);
    logic [1:0] i2;
    logic [7:0] e;
    bit         ir;
    i2 = idx[1:0];
    for (int k = 0; k < ticks * 8; k++) begin
      ir = mark && ((k % 4) < 2);
      e  = {3'b000, i2, 1'b1, mark, ir};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_frame(input int idx);
    logic [7:0] b[4];
    logic [7:0] by;
    b[0] = addr_t[idx];
    b[1] = ~addr_t[idx];
    b[2] = cmd_t[idx];
    b[3] = ~cmd_t[idx];
    push_seg(1'b1, 16, idx);
    push_seg(1'b0, 8, idx);
    for (int j = 0; j < 4; j++) begin
      by = b[j];
      for (int n = 0; n < 8; n++) begin
        push_seg(1'b1, 1, idx);
        push_seg(1'b0, by[n] ? 3 : 1, idx);
      end
    end
    push_seg(1'b1, 1, idx);
    push_seg(1'b0, 64, idx);
  endtask

  // driver + scoreboard: raise start, compare every clock against exp_q
  task automatic run_and_compare(input string name, input bit disturb, input int rep_drop_at);
    int         n;
    bit         bad;
    bit         idle_ok;
    int         width;
    logic [7:0] e;
    n     = exp_q.size();
    bad   = 1'b0;
    width = $urandom_range(1, 2);
    env_hist.delete();
    ui_in[0] = 1'b1;
    step();
    if (width == 1) ui_in[0] = 1'b0;
    step();
    ui_in[0] = 1'b0;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL %s_latency: uo_out=%h expected 00", name, uo_out);
    end
    for (int k = 0; k < n; k++) begin
      step();
      e = exp_q.pop_front();
      env_hist.push_back(uo_out[1]);
      if (!bad) begin
        checks++;
        if (uo_out !== e) begin
          errors++;
          bad = 1'b1;
          $display("FAIL %s cycle %0d: uo_out=%h expected %h", name, k, uo_out, e);
        end
      end
      if (disturb && k > 10 && k < n - 40) ui_in[0] = ($urandom_range(0, 3) == 0);
      if (k == rep_drop_at) ui_in[2] = 1'b0;
    end
    ui_in[0] = 1'b0;
    idle_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (uo_out !== 8'h00) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL %s_end_idle: uo_out=%h expected 00", name, uo_out);
    end
  endtask

  function automatic int run_len(input bit v, inout int p);
    int c;
    c = 0;
    while (p < env_hist.size() && env_hist[p] == v) begin
      c++;
      p++;
    end
    return c;
  endfunction

  task automatic test_reset();
    bit ok;
    rst_n = 1'b1;
    ui_in = 8'h80;
    step();
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_value: uo_out=%h uio_oe=%h uio_out=%h expected 00", uo_out, uio_oe, uio_out);
    end
    step();
    rst_n = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_idle: uo_out=%h uio_oe=%h expected 00", uo_out, uio_oe);
    end
  endtask

  task automatic test_full_sequence();
    int          p;
    int          m;
    int          s;
    bit          fmt_ok;
    logic [31:0] w;
    do_reset();
    repeat ($urandom_range(0, 20)) step();
    for (int i = 0; i < 4; i++) push_frame(i);
    run_and_compare("full", 1'b0, -1);
    // decode frame 0 from the captured envelope alone
    p = 0;
    m = run_len(1'b1, p);
    checks++;
    if (m != 128) begin
      errors++;
      $display("FAIL lead_mark_len: got %0d expected 128", m);
    end
    s = run_len(1'b0, p);
    checks++;
    if (s != 64) begin
      errors++;
      $display("FAIL lead_space_len: got %0d expected 64", s);
    end
    fmt_ok = 1'b1;
    w = 32'h0;
    for (int i = 0; i < 32; i++) begin
      m = run_len(1'b1, p);
      s = run_len(1'b0, p);
      if (m != 8 || (s != 8 && s != 24)) fmt_ok = 1'b0;
      w[i] = (s == 24);
    end
    checks++;
    if (!fmt_ok || w !== 32'hF708FB04) begin
      errors++;
      $display("FAIL frame0_decode: got %h fmt_ok=%0d expected f708fb04", w, fmt_ok);
    end
    m = run_len(1'b1, p);
    s = run_len(1'b0, p);
    checks++;
    if (m != 8 || s != 512) begin
      errors++;
      $display("FAIL stop_gap: stop %0d gap %0d expected 8 and 512", m, s);
    end
  endtask

  task automatic test_back_to_back_edges();
    do_reset();
    for (int i = 0; i < 4; i++) push_frame(i);
    run_and_compare("busy_edges", 1'b1, -1);
  endtask

  task automatic test_abort();
    int  t;
    bit  ok;
    do_reset();
    ui_in[0] = 1'b1;
    step();
    step();
    ui_in[0] = 1'b0;
    t = 0;
    while (uo_out[4:3] !== 2'd1 && t < 6000) begin
      step();
      t++;
    end
    checks++;
    if (t >= 6000) begin
      errors++;
      $display("FAIL abort_reach_frame1: index=%0d expected 1 within 6000 clocks", uo_out[4:3]);
    end
    repeat ($urandom_range(0, 600)) step();
    ui_in[1] = 1'b1;
    step();
    step();
    step();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_3clk: uo_out=%h expected 00", uo_out);
    end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (uo_out !== 8'h00) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_hold: uo_out=%h expected 00", uo_out);
    end
    ui_in[1] = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 4; i++) push_frame(i);
    run_and_compare("after_abort", 1'b0, -1);
    // abort and start rising together: abort wins
    ui_in[0] = 1'b1;
    ui_in[1] = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (uo_out !== 8'h00) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_vs_start: uo_out=%h expected 00", uo_out);
    end
    ui_in[0] = 1'b0;
    ui_in[1] = 1'b0;
    repeat (5) step();
    ui_in[0] = 1'b1;
    step();
    step();
    step();
    checks++;
    if (uo_out !== 8'h07) begin
      errors++;
      $display("FAIL restart_after_abort: uo_out=%h expected 07", uo_out);
    end
    ui_in[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    ui_in[0] = 1'b1;
    step();
    step();
    ui_in[0] = 1'b0;
    repeat ($urandom_range(100, 3000)) step();
    ui_in[0] = 1'b1;
    rst_n = 1'b1;
    step();
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: uo_out=%h uio_oe=%h expected 00", uo_out, uio_oe);
    end
    rst_n = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (uo_out !== 8'h00) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_high_at_release: uo_out=%h expected 00", uo_out);
    end
    ui_in[0] = 1'b0;
    repeat (5) step();
    ui_in[0] = 1'b1;
    step();
    step();
    step();
    checks++;
    if (uo_out !== 8'h07) begin
      errors++;
      $display("FAIL fresh_edge_after_reset: uo_out=%h expected 07", uo_out);
    end
    ui_in[0] = 1'b0;
  endtask

  task automatic test_repeat();
    int drop;
    do_reset();
    ui_in[2] = 1'b1;
    for (int i = 0; i < 4; i++) push_frame(i);
`ifdef TVBG_REPEAT_EN
    drop = exp_q.size() + 100;
    for (int i = 0; i < 4; i++) push_frame(i);
`else
    drop = -1;
`endif
    run_and_compare("repeat", 1'b0, drop);
    ui_in[2] = 1'b0;
  endtask

  initial begin
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h80;
    rst_n  = 1'b1;
    test_reset();
    test_full_sequence();
    test_back_to_back_edges();
    test_abort();
    test_reset_mid();
    test_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
